clock_time_core: RTL and testbench
==================================

Name: clock_time_core

Overview:
- Timekeeping counterpart to the time-set mode block.
- Owns the running time value and publishes TIME_CURR; the set mode reads TIME_CURR when it is entered.
- On exit from set mode, loads the returned TIME_SET, normalises it and resumes counting.
- Derives its own 1 s tick from CLOCK_1ms. Only one clock domain.

Parameters:
- TICKS_PER_SEC, 1000, CLOCK_1ms cycles per one-second tick.
- TIME_MAX, 3599, highest time value. Wraps to 0 after this value.

Ports:
- Interface (already decided): reset RESET, asynchronous, active-high; clock CLOCK_1ms.
- CLOCK_1ms  in  1  system clock, 1 kHz.
- RESET  in  1  async active-high reset.
- SET_ACTIVE  in  1  high while the time-set mode is enabled.
- TIME_SET  in  12  value edited by set mode; sampled only at the LOAD state.
- time_flows  in  1  from set mode; 0 until the first set-mode entry after reset.
- TIME_CURR  out  12  current time, 0..TIME_MAX.
- TICK_1s  out  1  one-cycle pulse, coincident with each TIME_CURR increment.
- ROLLOVER  out  1  one-cycle pulse when TIME_CURR wraps from TIME_MAX to 0.
- LOADED  out  1  one-cycle pulse when TIME_SET is loaded.

Behaviour:
- Reset values: TIME_CURR=0, TICK_1s=0, ROLLOVER=0, LOADED=0, prescaler cnt=0, set_d=0, state=IDLE.
- set_d is SET_ACTIVE registered one cycle. set_fall = ~SET_ACTIVE & set_d.
- States:
  - IDLE: TIME_CURR and cnt held. Go to HOLD if SET_ACTIVE=1. Else go to RUN if time_flows=1.
  - RUN: cnt increments each cycle. When cnt==TICKS_PER_SEC-1:
    - cnt<=0, TICK_1s<=1 on the same edge TIME_CURR updates.
    - If TIME_CURR==TIME_MAX: TIME_CURR<=0 and ROLLOVER<=1.
    - Otherwise TIME_CURR<=TIME_CURR+1.
    - Go to HOLD if SET_ACTIVE=1.
  - HOLD: counting frozen and cnt held, so TIME_CURR is stable while set mode edits. Go to LOAD on set_fall.
  - LOAD (exactly one cycle):
    - TIME_CURR<=norm(TIME_SET), where norm(x) = x-3600 if x>=3600, else x. This covers the 12-bit range 3600..4095 → 0..495.
    - cnt<=0, LOADED<=1.
    - Next state RUN if time_flows=1, else IDLE.
- Latency:
  - Set-mode exit to new TIME_CURR: 2 edges (set_d edge, then LOAD edge).
  - First tick after load: TICKS_PER_SEC cycles after LOAD.
- Simultaneous events:
  - RESET overrides everything, at any time, including mid-LOAD.
  - SET_ACTIVE rising on a terminal-count cycle: the tick still completes and the transition to HOLD happens on that same edge. The tick is not lost.
  - SET_ACTIVE pulse shorter than 1 cycle is not defined (the source is synchronous to the same clock).
  - SET_ACTIVE re-asserted during LOAD: LOAD completes, then the next state evaluation sends the block to HOLD.
- Arithmetic: all 12-bit unsigned. TIME_CURR never exceeds TIME_MAX.
- TICK_1s, ROLLOVER and LOADED are registered and zero in every other cycle.

Optional Feature:
- Macro ALARM_MATCH_EN.
- With it: adds input ALARM_TIME[11:0], input ALARM_ARMED[0:0] and output ALARM_HIT[0:0].
  - ALARM_HIT pulses for one cycle, coincident with TICK_1s, when the new TIME_CURR equals ALARM_TIME and ALARM_ARMED=1.
  - A LOAD that lands exactly on ALARM_TIME does not trigger.
  - ALARM_HIT resets to 0.
- Without it: these ports are absent and no comparator logic is built.

Decomposition:
- Shared package (the alarm-clock constants package):
  - TIME_MAX=3599 and TIME_WRAP=3600.
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, HOLD=2'd2, LOAD=2'd3.
  - Digit weights 600/60/10/1, shared with the set and alarm modes.
- One sub-module: tick_prescaler.
  - Parameter TICKS_PER_SEC. Inputs clear, run.
  - Outputs cnt and terminal.
  - Reused by the alarm/timer modes.

Test Plan:
- Reset, time_flows=0, run 5000 cycles → TIME_CURR stays 0; no TICK_1s.
- SET_ACTIVE=1 for 10 cycles with TIME_SET=754 and time_flows=1, then SET_ACTIVE=0 → LOADED pulses 2 edges after the fall; TIME_CURR=754; TIME_CURR=755 exactly 1000 cycles after LOAD, with TICK_1s.
- Load 3599, run 1000 cycles → TIME_CURR=0; ROLLOVER and TICK_1s pulse together for one cycle.
- Load TIME_SET=4000 → TIME_CURR=400.
- Running at TIME_CURR=100 with cnt=500, raise SET_ACTIVE for 3000 cycles → TIME_CURR stays 100 throughout; after exit it takes TIME_SET.
- Assert RESET during LOAD → all outputs 0, state IDLE. With ALARM_MATCH_EN: ALARM_TIME=101, armed, load 100 → ALARM_HIT pulses at the next tick only.

Source files
------------

// File: rtl/clock_time_core_pkg.sv
// ============================================================================
// Module   : clock_time_core_pkg
// Brief    : Shared alarm-clock constants, FSM state encoding and the time
//            normalisation helper used by the set, alarm and timekeeping blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_time_core_pkg;

    typedef logic [11:0] time_t;

    // Time range in seconds: 0..59:59
    localparam time_t TIME_MAX  = 12'd3599;
    localparam time_t TIME_WRAP = 12'd3600;

    // Timekeeping FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] LOAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_HOLD = HOLD,
        ST_LOAD = LOAD
    } state_t;

    // Digit weights for mm:ss display and editing
    localparam time_t W_MIN_TENS = 12'd600;
    localparam time_t W_MIN_ONES = 12'd60;
    localparam time_t W_SEC_TENS = 12'd10;
    localparam time_t W_SEC_ONES = 12'd1;

    // Fold an edited value that overshot the range back into 0..wrap-1
    function automatic time_t norm_time(input time_t x, input time_t wrap);
        return (x >= wrap) ? time_t'(x - wrap) : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_time_core_if.sv
// ============================================================================
// Module   : clock_time_core_if
// Brief    : Bus between the time-set mode (master) and the timekeeping core
//            (slave). Alarm match signals exist only when ALARM_MATCH_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_time_core_if;
    import clock_time_core_pkg::*;

    logic  SET_ACTIVE;
    time_t TIME_SET;
    logic  time_flows;
    time_t TIME_CURR;
    logic  TICK_1s;
    logic  ROLLOVER;
    logic  LOADED;
`ifdef ALARM_MATCH_EN
    time_t ALARM_TIME;
    logic  ALARM_ARMED;
    logic  ALARM_HIT;

    modport master (
        output SET_ACTIVE, TIME_SET, time_flows, ALARM_TIME, ALARM_ARMED,
        input  TIME_CURR, TICK_1s, ROLLOVER, LOADED, ALARM_HIT
    );
    modport slave (
        input  SET_ACTIVE, TIME_SET, time_flows, ALARM_TIME, ALARM_ARMED,
        output TIME_CURR, TICK_1s, ROLLOVER, LOADED, ALARM_HIT
    );
`else
    modport master (
        output SET_ACTIVE, TIME_SET, time_flows,
        input  TIME_CURR, TICK_1s, ROLLOVER, LOADED
    );
    modport slave (
        input  SET_ACTIVE, TIME_SET, time_flows,
        output TIME_CURR, TICK_1s, ROLLOVER, LOADED
    );
`endif
endinterface

`default_nettype wire

// File: rtl/clock_time_core_tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Brief    : Counts CLOCK_1ms cycles while run is high and flags the last
//            cycle of each TICKS_PER_SEC period. clear has priority over run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter  int unsigned TICKS_PER_SEC = 1000,
    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
    input  wire logic             CLOCK_1ms,
    input  wire logic             RESET,
    input  wire logic             clear,
    input  wire logic             run,
    output logic      [CNT_W-1:0] cnt,
    output logic                  terminal
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;

    assign cnt      = r_cnt;
    assign terminal = run && (r_cnt == c_last);

    // Sub-second counter: wraps on terminal, frozen when not running
    always_ff @(posedge CLOCK_1ms or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= terminal ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/clock_time_core.sv
// ============================================================================
// Module   : clock_time_core
// Brief    : Running mm:ss time base. Counts seconds from CLOCK_1ms, freezes
//            while set mode is active and loads the edited time on exit.
//            Optional ALARM_MATCH_EN adds an alarm comparator on each tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_time_core #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned TIME_MAX      = 3599
) (
    input  wire logic         CLOCK_1ms,
    input  wire logic         RESET,
    clock_time_core_if.slave  bus
);
    import clock_time_core_pkg::*;

    localparam time_t       c_time_max  = 12'(TIME_MAX);
    localparam time_t       c_time_wrap = 12'(TIME_MAX + 1);
    localparam int unsigned c_cnt_w     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(TICKS_PER_SEC - 1);

    state_t             r_state;
    logic               r_set_d;
    time_t              r_time;
    logic               r_tick;
    logic               r_rollover;
    logic               r_loaded;
    logic [c_cnt_w-1:0] w_cnt;
    logic               w_terminal;
    logic               w_tick;
    logic               w_set_fall;
    time_t              w_next_time;

    assign w_set_fall  = ~bus.SET_ACTIVE & r_set_d;
    assign w_tick      = w_terminal && (w_cnt == c_last_cnt);
    assign w_next_time = (r_time == c_time_max) ? '0 : r_time + 12'd1;

    tick_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .CLOCK_1ms (CLOCK_1ms),
        .RESET     (RESET),
        .clear     (r_state == ST_LOAD),
        .run       (r_state == ST_RUN),
        .cnt       (w_cnt),
        .terminal  (w_terminal)
    );

    // Delayed copy of SET_ACTIVE for falling-edge detection
    always_ff @(posedge CLOCK_1ms or posedge RESET) begin
        if (RESET) r_set_d <= 1'b0;
        else       r_set_d <= bus.SET_ACTIVE;
    end

    // Timekeeping FSM with registered time value and single-cycle pulses
    always_ff @(posedge CLOCK_1ms or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_time     <= '0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
            r_loaded   <= 1'b0;
        end else begin
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
            r_loaded   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.SET_ACTIVE)      r_state <= ST_HOLD;
                    else if (bus.time_flows) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // A tick on the same edge as set entry still completes
                    if (w_tick) begin
                        r_time     <= w_next_time;
                        r_tick     <= 1'b1;
                        r_rollover <= (r_time == c_time_max);
                    end
                    if (bus.SET_ACTIVE) r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_set_fall) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_time   <= norm_time(bus.TIME_SET, c_time_wrap);
                    r_loaded <= 1'b1;
                    r_state  <= bus.time_flows ? ST_RUN : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.TIME_CURR = r_time;
    assign bus.TICK_1s   = r_tick;
    assign bus.ROLLOVER  = r_rollover;
    assign bus.LOADED    = r_loaded;

`ifdef ALARM_MATCH_EN
    logic r_alarm_hit;

    // Alarm fires only on a counted second, never on a load
    always_ff @(posedge CLOCK_1ms or posedge RESET) begin
        if (RESET) begin
            r_alarm_hit <= 1'b0;
        end else begin
            r_alarm_hit <= (r_state == ST_RUN) && w_tick && bus.ALARM_ARMED &&
                           (w_next_time == bus.ALARM_TIME);
        end
    end

    assign bus.ALARM_HIT = r_alarm_hit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_time_core.sv
// ============================================================================
// Module   : tb_clock_time_core
// Brief    : Self-checking bench for clock_time_core. Expected time is derived
//            from the load value and elapsed cycles; ALARM_MATCH_EN adds an
//            alarm scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_time_core;

    logic CLOCK_1ms = 1'b0;
    logic RESET     = 1'b1;
    int   n_checks  = 0;
    int   n_pass    = 0;

    clock_time_core_if bus ();

    clock_time_core #(
        .TICKS_PER_SEC (1000),
        .TIME_MAX      (3599)
    ) dut (
        .CLOCK_1ms (CLOCK_1ms),
        .RESET     (RESET),
        .bus       (bus)
    );

    always #5 CLOCK_1ms = ~CLOCK_1ms;

    // Advance one clock and settle just after the rising edge
    task automatic cyc();
        @(posedge CLOCK_1ms);
        #1;
    endtask

    // Enter set mode for 'hold' cycles, leave it, and return just after LOAD
    task automatic do_load(input int v, input int hold);
        bus.TIME_SET   = 12'(v);
        bus.SET_ACTIVE = 1'b1;
        repeat (hold) cyc();
        bus.SET_ACTIVE = 1'b0;
        cyc();
        cyc();
    endtask

    function automatic int norm_ref(input int v);
        return v % 3600;
    endfunction

    task automatic test_reset();
        int bad;
        repeat (2) cyc();
        n_checks++; if (bus.TIME_CURR !== 12'd0) $display("FAIL reset_time: got %0d expected 0", bus.TIME_CURR); else n_pass++;
        n_checks++; if (bus.TICK_1s !== 1'b0)    $display("FAIL reset_tick: got %0b expected 0", bus.TICK_1s);    else n_pass++;
        n_checks++; if (bus.ROLLOVER !== 1'b0)   $display("FAIL reset_roll: got %0b expected 0", bus.ROLLOVER);   else n_pass++;
        n_checks++; if (bus.LOADED !== 1'b0)     $display("FAIL reset_loaded: got %0b expected 0", bus.LOADED);   else n_pass++;
        RESET = 1'b0;
        bad = 0;
        for (int k = 0; k < 5000; k++) begin
            cyc();
            if (bus.TIME_CURR !== 12'd0 || bus.TICK_1s !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL idle_no_flow: got %0d bad cycles expected 0", bad); else n_pass++;
    endtask

    task automatic test_load_latency();
        int bad;
        bus.time_flows = 1'b1;
        bus.TIME_SET   = 12'd754;
        bus.SET_ACTIVE = 1'b1;
        repeat (10) cyc();
        bus.SET_ACTIVE = 1'b0;
        cyc();
        n_checks++; if (bus.LOADED !== 1'b0) $display("FAIL load_early: got %0b expected 0", bus.LOADED); else n_pass++;
        cyc();
        n_checks++; if (bus.LOADED !== 1'b1) $display("FAIL load_pulse: got %0b expected 1", bus.LOADED); else n_pass++;
        n_checks++; if (bus.TIME_CURR !== 12'd754) $display("FAIL load_value: got %0d expected 754", bus.TIME_CURR); else n_pass++;
        bad = 0;
        for (int k = 1; k < 1000; k++) begin
            cyc();
            if (bus.TIME_CURR !== 12'd754 || bus.TICK_1s !== 1'b0 || bus.LOADED !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL pre_tick: got %0d bad cycles expected 0", bad); else n_pass++;
        cyc();
        n_checks++; if (bus.TIME_CURR !== 12'd755) $display("FAIL first_tick_time: got %0d expected 755", bus.TIME_CURR); else n_pass++;
        n_checks++; if (bus.TICK_1s !== 1'b1) $display("FAIL first_tick_pulse: got %0b expected 1", bus.TICK_1s); else n_pass++;
        cyc();
        n_checks++; if (bus.TICK_1s !== 1'b0) $display("FAIL tick_width: got %0b expected 0", bus.TICK_1s); else n_pass++;
    endtask

    task automatic test_rollover();
        do_load(3599, 4);
        n_checks++; if (bus.TIME_CURR !== 12'd3599) $display("FAIL roll_load: got %0d expected 3599", bus.TIME_CURR); else n_pass++;
        repeat (999) cyc();
        cyc();
        n_checks++; if (bus.TIME_CURR !== 12'd0) $display("FAIL roll_time: got %0d expected 0", bus.TIME_CURR); else n_pass++;
        n_checks++; if (bus.ROLLOVER !== 1'b1 || bus.TICK_1s !== 1'b1)
            $display("FAIL roll_pulse: got roll=%0b tick=%0b expected 1 1", bus.ROLLOVER, bus.TICK_1s); else n_pass++;
        cyc();
        n_checks++; if (bus.ROLLOVER !== 1'b0 || bus.TICK_1s !== 1'b0)
            $display("FAIL roll_width: got roll=%0b tick=%0b expected 0 0", bus.ROLLOVER, bus.TICK_1s); else n_pass++;
    endtask

    task automatic test_normalise();
        int vals [4] = '{4000, 3600, 4095, 0};
        for (int i = 0; i < 4; i++) begin
            do_load(vals[i], 2);
            n_checks++;
            if (bus.TIME_CURR !== 12'(norm_ref(vals[i])))
                $display("FAIL norm_%0d: got %0d expected %0d", vals[i], bus.TIME_CURR, norm_ref(vals[i]));
            else n_pass++;
        end
    endtask

    task automatic test_hold_freeze();
        int bad;
        int v;
        do_load(99, 3);
        repeat (1500) cyc();
        n_checks++; if (bus.TIME_CURR !== 12'd100) $display("FAIL hold_pre: got %0d expected 100", bus.TIME_CURR); else n_pass++;
        v = int'($urandom_range(0, 4095));
        bus.TIME_SET   = 12'(v);
        bus.SET_ACTIVE = 1'b1;
        bad = 0;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            if (bus.TIME_CURR !== 12'd100 || bus.TICK_1s !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL hold_frozen: got %0d bad cycles expected 0", bad); else n_pass++;
        bus.SET_ACTIVE = 1'b0;
        cyc();
        cyc();
        n_checks++; if (bus.TIME_CURR !== 12'(norm_ref(v)))
            $display("FAIL hold_exit: got %0d expected %0d", bus.TIME_CURR, norm_ref(v)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad;
        bus.TIME_SET   = 12'd2222;
        bus.SET_ACTIVE = 1'b1;
        repeat (3) cyc();
        bus.SET_ACTIVE = 1'b0;
        cyc();
        bus.SET_ACTIVE = 1'b1;
        cyc();
        n_checks++; if (bus.LOADED !== 1'b1 || bus.TIME_CURR !== 12'd2222)
            $display("FAIL reentry_load: got loaded=%0b time=%0d expected 1 2222", bus.LOADED, bus.TIME_CURR); else n_pass++;
        bad = 0;
        for (int k = 0; k < 1500; k++) begin
            cyc();
            if (bus.TIME_CURR !== 12'd2222 || bus.TICK_1s !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL reentry_hold: got %0d bad cycles expected 0", bad); else n_pass++;
        bus.SET_ACTIVE = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_random();
        int v, n, base, bad_t, bad_p;
        int exp_t;
        bit exp_tick, exp_roll;
        for (int i = 0; i < 6; i++) begin
            v = (i % 2 == 1) ? int'($urandom_range(3595, 4095)) : int'($urandom_range(0, 4095));
            n = int'($urandom_range(1, 2500));
            do_load(v, int'($urandom_range(1, 20)));
            base  = norm_ref(v);
            bad_t = 0;
            bad_p = 0;
            for (int k = 1; k <= n; k++) begin
                cyc();
                exp_t    = (base + k / 1000) % 3600;
                exp_tick = (k % 1000 == 0);
                exp_roll = exp_tick && (exp_t == 0);
                if (bus.TIME_CURR !== 12'(exp_t)) bad_t++;
                if (bus.TICK_1s !== exp_tick || bus.ROLLOVER !== exp_roll || bus.LOADED !== 1'b0) bad_p++;
            end
            n_checks++; if (bad_t != 0) $display("FAIL rand_time_%0d: got %0d bad cycles expected 0 (load %0d run %0d)", i, bad_t, v, n); else n_pass++;
            n_checks++; if (bad_p != 0) $display("FAIL rand_pulse_%0d: got %0d bad cycles expected 0 (load %0d run %0d)", i, bad_p, v, n); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_load();
        int bad;
        do_load(500, 2);
        bus.TIME_SET   = 12'd1234;
        bus.SET_ACTIVE = 1'b1;
        repeat (3) cyc();
        bus.SET_ACTIVE = 1'b0;
        cyc();
        RESET = 1'b1;
        #1;
        n_checks++; if (bus.TIME_CURR !== 12'd0 || bus.LOADED !== 1'b0 || bus.TICK_1s !== 1'b0 || bus.ROLLOVER !== 1'b0)
            $display("FAIL async_reset: got time=%0d loaded=%0b tick=%0b roll=%0b expected all 0",
                     bus.TIME_CURR, bus.LOADED, bus.TICK_1s, bus.ROLLOVER); else n_pass++;
        bus.time_flows = 1'b0;
        cyc();
        RESET = 1'b0;
        bad = 0;
        for (int k = 0; k < 1500; k++) begin
            cyc();
            if (bus.TIME_CURR !== 12'd0 || bus.LOADED !== 1'b0 || bus.TICK_1s !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL reset_idle: got %0d bad cycles expected 0", bad); else n_pass++;
    endtask

`ifdef ALARM_MATCH_EN
    task automatic test_alarm();
        int hits;
        bus.time_flows  = 1'b1;
        bus.ALARM_TIME  = 12'd101;
        bus.ALARM_ARMED = 1'b1;
        do_load(100, 2);
        n_checks++; if (bus.ALARM_HIT !== 1'b0) $display("FAIL alarm_on_load: got %0b expected 0", bus.ALARM_HIT); else n_pass++;
        hits = 0;
        for (int k = 1; k < 1000; k++) begin
            cyc();
            if (bus.ALARM_HIT !== 1'b0) hits++;
        end
        n_checks++; if (hits != 0) $display("FAIL alarm_early: got %0d hits expected 0", hits); else n_pass++;
        cyc();
        n_checks++; if (bus.ALARM_HIT !== 1'b1 || bus.TIME_CURR !== 12'd101)
            $display("FAIL alarm_hit: got hit=%0b time=%0d expected 1 101", bus.ALARM_HIT, bus.TIME_CURR); else n_pass++;
        hits = 0;
        for (int k = 0; k < 1000; k++) begin
            cyc();
            if (bus.ALARM_HIT !== 1'b0) hits++;
        end
        n_checks++; if (hits != 0) $display("FAIL alarm_once: got %0d hits expected 0", hits); else n_pass++;
        do_load(101, 2);
        hits = (bus.ALARM_HIT !== 1'b0) ? 1 : 0;
        cyc();
        if (bus.ALARM_HIT !== 1'b0) hits++;
        n_checks++; if (hits != 0) $display("FAIL alarm_load_match: got %0d hits expected 0", hits); else n_pass++;
    endtask
`endif

    initial begin
        bus.SET_ACTIVE = 1'b0;
        bus.TIME_SET   = 12'd0;
        bus.time_flows = 1'b0;
`ifdef ALARM_MATCH_EN
        bus.ALARM_TIME  = 12'd0;
        bus.ALARM_ARMED = 1'b0;
`endif
        test_reset();
        test_load_latency();
        test_rollover();
        test_normalise();
        test_hold_freeze();
        test_back_to_back();
        test_random();
        test_reset_mid_load();
`ifdef ALARM_MATCH_EN
        test_alarm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
